// File: rtl/ex_operand_stage.sv
// Decode-to-execute pipeline register: forwards rs/rt from EX/MEM/WB, selects
// sa/imm operands, stalls on load-use and handshakes with decode and memory.
module ex_fwd_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_src,
  input  logic [DATA_WIDTH-1:0] i_rf_value,
  input  logic                  i_ex_fwd_ok,
  input  logic [REG_ADDR_W-1:0] i_ex_dest,
  input  logic [DATA_WIDTH-1:0] i_ex_result,
  input  logic                  i_mem_valid,
  input  logic [REG_ADDR_W-1:0] i_mem_dest,
  input  logic [DATA_WIDTH-1:0] i_mem_result,
  input  logic                  i_wb_valid,
  input  logic [REG_ADDR_W-1:0] i_wb_dest,
  input  logic [DATA_WIDTH-1:0] i_wb_result,
  output logic [DATA_WIDTH-1:0] o_value
);
  // $0 is checked first so a zero destination downstream can never leak a value
  always_comb begin
    o_value = i_rf_value;
    if (i_src == '0)                                 o_value = '0;
    else if (i_ex_fwd_ok && i_ex_dest == i_src)      o_value = i_ex_result;
    else if (i_mem_valid && i_mem_dest == i_src)     o_value = i_mem_result;
    else if (i_wb_valid && i_wb_dest == i_src)       o_value = i_wb_result;
  end
endmodule

module ex_operand_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  de_valid,
  output logic                  de_ready,
  input  logic [3:0]            de_alu_op,
  input  logic [REG_ADDR_W-1:0] de_rs,
  input  logic [REG_ADDR_W-1:0] de_rt,
  input  logic [DATA_WIDTH-1:0] de_rs_value,
  input  logic [DATA_WIDTH-1:0] de_rt_value,
  input  logic [DATA_WIDTH-1:0] de_imm,
  input  logic [REG_ADDR_W-1:0] de_sa,
  input  logic                  de_src1_is_sa,
  input  logic                  de_src2_is_imm,
  input  logic [REG_ADDR_W-1:0] de_dest,
  input  logic                  de_is_load,
  input  logic [DATA_WIDTH-1:0] de_pc,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic [DATA_WIDTH-1:0] mem_result,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic [DATA_WIDTH-1:0] wb_result,
  input  logic                  mem_allowin,
  output logic                  ex_valid,
  output logic [3:0]            ex_alu_op,
  output logic [DATA_WIDTH-1:0] ex_alu_a,
  output logic [DATA_WIDTH-1:0] ex_alu_b,
  output logic [DATA_WIDTH-1:0] ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic                  ex_is_load,
  output logic [DATA_WIDTH-1:0] ex_pc
);
  localparam int NUM_SRC = 2;

  logic                  r_valid;
  logic [3:0]            r_alu_op;
  logic [DATA_WIDTH-1:0] r_a, r_b, r_store, r_pc;
  logic [REG_ADDR_W-1:0] r_dest;
  logic                  r_is_load;

  logic                                 w_allowin, w_hazard, w_ex_fwd_ok;
  logic [NUM_SRC-1:0][REG_ADDR_W-1:0]   w_src;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]   w_rf, w_fwd;
  logic [DATA_WIDTH-1:0]                w_a_next, w_b_next;

  assign w_allowin = ~r_valid | mem_allowin;

  // rt is always compared because stores consume it as data
  assign w_hazard = r_valid & r_is_load & (r_dest != '0) &
                    ((~de_src1_is_sa & (r_dest == de_rs)) | (r_dest == de_rt));

  assign de_ready    = w_allowin & ~w_hazard;
  assign w_ex_fwd_ok = r_valid & ~r_is_load;

  assign w_src = {de_rt, de_rs};
  assign w_rf  = {de_rt_value, de_rs_value};

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_fwd
      ex_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd (
        .i_src       (w_src[g]),
        .i_rf_value  (w_rf[g]),
        .i_ex_fwd_ok (w_ex_fwd_ok),
        .i_ex_dest   (r_dest),
        .i_ex_result (alu_result),
        .i_mem_valid (mem_valid),
        .i_mem_dest  (mem_dest),
        .i_mem_result(mem_result),
        .i_wb_valid  (wb_valid),
        .i_wb_dest   (wb_dest),
        .i_wb_result (wb_result),
        .o_value     (w_fwd[g])
      );
    end
  endgenerate

  assign w_a_next = de_src1_is_sa ? {{(DATA_WIDTH-REG_ADDR_W){1'b0}}, de_sa} : w_fwd[0];
  assign w_b_next = de_src2_is_imm ? de_imm : w_fwd[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid   <= 1'b0;
      r_alu_op  <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_store   <= '0;
      r_dest    <= '0;
      r_is_load <= 1'b0;
      r_pc      <= '0;
    end else if (w_allowin) begin
      r_valid <= de_valid & ~w_hazard;
      if (de_valid && de_ready) begin
        r_alu_op  <= de_alu_op;
        r_a       <= w_a_next;
        r_b       <= w_b_next;
        r_store   <= w_fwd[1];
        r_dest    <= de_dest;
        r_is_load <= de_is_load;
        r_pc      <= de_pc;
      end
    end
  end

  assign ex_valid      = r_valid;
  assign ex_alu_op     = r_alu_op;
  assign ex_alu_a      = r_a;
  assign ex_alu_b      = r_b;
  assign ex_store_data = r_store;
  assign ex_dest       = r_dest;
  assign ex_is_load    = r_is_load;
  assign ex_pc         = r_pc;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: vector table through a scoreboard queue, plus
// load-use, back-pressure and asynchronous reset sequences.
module tb_ex_operand_stage;
  logic        clk = 1'b0;
  logic        resetn;
  logic        de_valid, de_ready;
  logic [3:0]  de_alu_op;
  logic [4:0]  de_rs, de_rt, de_sa, de_dest;
  logic [31:0] de_rs_value, de_rt_value, de_imm, de_pc;
  logic        de_src1_is_sa, de_src2_is_imm, de_is_load;
  logic [31:0] alu_result, mem_result, wb_result;
  logic        mem_valid, wb_valid, mem_allowin;
  logic [4:0]  mem_dest, wb_dest;
  logic        ex_valid, ex_is_load;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_alu_a, ex_alu_b, ex_store_data, ex_pc;
  logic [4:0]  ex_dest;

  ex_operand_stage #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .resetn(resetn), .de_valid(de_valid), .de_ready(de_ready),
    .de_alu_op(de_alu_op), .de_rs(de_rs), .de_rt(de_rt),
    .de_rs_value(de_rs_value), .de_rt_value(de_rt_value), .de_imm(de_imm),
    .de_sa(de_sa), .de_src1_is_sa(de_src1_is_sa), .de_src2_is_imm(de_src2_is_imm),
    .de_dest(de_dest), .de_is_load(de_is_load), .de_pc(de_pc),
    .alu_result(alu_result), .mem_valid(mem_valid), .mem_dest(mem_dest),
    .mem_result(mem_result), .wb_valid(wb_valid), .wb_dest(wb_dest),
    .wb_result(wb_result), .mem_allowin(mem_allowin), .ex_valid(ex_valid),
    .ex_alu_op(ex_alu_op), .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_is_load(ex_is_load),
    .ex_pc(ex_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rs, rt;
    logic [31:0] rsv, rtv, imm;
    logic [4:0]  sa;
    logic        s1sa, s2imm;
    logic [4:0]  dest;
    logic        ld;
    logic [31:0] alu;
    logic        mv;
    logic [4:0]  md;
    logic [31:0] mr;
    logic        wv;
    logic [4:0]  wd;
    logic [31:0] wr;
    logic [31:0] ea, eb, est;
  } vec_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a, b, st;
    logic [4:0]  dest;
    logic        ld;
    logic [31:0] pc;
  } exp_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];
  exp_t sb[$];
  exp_t last_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic [31:0] pc);
    de_valid = 1'b1;       de_alu_op = v.op;     de_rs = v.rs;        de_rt = v.rt;
    de_rs_value = v.rsv;   de_rt_value = v.rtv;  de_imm = v.imm;      de_sa = v.sa;
    de_src1_is_sa = v.s1sa; de_src2_is_imm = v.s2imm; de_dest = v.dest;
    de_is_load = v.ld;     de_pc = pc;           alu_result = v.alu;
    mem_valid = v.mv;      mem_dest = v.md;      mem_result = v.mr;
    wb_valid = v.wv;       wb_dest = v.wd;       wb_result = v.wr;
  endtask

  task automatic push(input vec_t v, input logic [31:0] pc);
    exp_t e;
    e.op = v.op; e.a = v.ea; e.b = v.eb; e.st = v.est;
    e.dest = v.dest; e.ld = v.ld; e.pc = pc;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, ".valid"}, {31'b0, ex_valid}, 32'd1);
    chk({tag, ".op"},    {28'b0, ex_alu_op}, {28'b0, e.op});
    chk({tag, ".a"},     ex_alu_a, e.a);
    chk({tag, ".b"},     ex_alu_b, e.b);
    chk({tag, ".st"},    ex_store_data, e.st);
    chk({tag, ".dest"},  {27'b0, ex_dest}, {27'b0, e.dest});
    chk({tag, ".ld"},    {31'b0, ex_is_load}, {31'b0, e.ld});
    chk({tag, ".pc"},    ex_pc, e.pc);
  endtask

  task automatic pop_check(input string tag);
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty, nothing expected", tag);
    end else begin
      last_e = sb.pop_front();
      check_out(tag, last_e);
    end
  endtask

  initial begin
    vec_t v;
    //          op     rs  rt  rsv           rtv           imm           sa   s1 s2 dest ld alu           mv md mr            wv wd wr      ea            eb            est
    vecs[0] = '{4'b0010, 5'd1,  5'd2,  32'h5,        32'h9,        32'h0,        5'd0, 1'b0,1'b0,5'd3, 1'b0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0, 32'h5,        32'h9,        32'h9};
    vecs[1] = '{4'b0110, 5'd3,  5'd1,  32'h111,      32'h2,        32'h0,        5'd0, 1'b0,1'b0,5'd4, 1'b0,32'h7,        1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0, 32'h7,        32'h2,        32'h2};
    vecs[2] = '{4'b0010, 5'd5,  5'd0,  32'h55,       32'hFFFFFFFF, 32'h0,        5'd0, 1'b0,1'b0,5'd7, 1'b0,32'hDEAD,     1'b1,5'd5,32'hAAAA0000, 1'b1,5'd5,32'h1, 32'hAAAA0000, 32'h0,        32'h0};
    vecs[3] = '{4'b0001, 5'd6,  5'd9,  32'h60,       32'h90,       32'h0,        5'd0, 1'b0,1'b0,5'd8, 1'b0,32'h0,        1'b1,5'd9,32'h99,       1'b1,5'd6,32'h66,32'h66,       32'h99,       32'h99};
    vecs[4] = '{4'b1010, 5'd0,  5'd0,  32'hFFFF,     32'hFFFF,     32'h0,        5'd0, 1'b0,1'b0,5'd10,1'b0,32'h0,        1'b1,5'd0,32'h12345678, 1'b1,5'd0,32'h9, 32'h0,        32'h0,        32'h0};
    vecs[5] = '{4'b0101, 5'd12, 5'd11, 32'h77,       32'h1,        32'h0,        5'd31,1'b1,1'b0,5'd13,1'b0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0, 32'h1F,       32'h1,        32'h1};
    vecs[6] = '{4'b0011, 5'd0,  5'd14, 32'h33,       32'h5,        32'h0000ABCD, 5'd0, 1'b0,1'b1,5'd14,1'b0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0, 32'h0,        32'h0000ABCD, 32'h5};
    vecs[7] = '{4'b0010, 5'd14, 5'd2,  32'h44,       32'h22,       32'h10,       5'd0, 1'b0,1'b1,5'd0, 1'b0,32'hABCD0000, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0, 32'hABCD0000, 32'h10,       32'h22};

    resetn = 1'b0; mem_allowin = 1'b1;
    drive('0, 32'h0); de_valid = 1'b0;
    #1;
    chk("reset.valid", {31'b0, ex_valid}, 32'd0);
    chk("reset.a", ex_alu_a, 32'h0);
    chk("reset.pc", ex_pc, 32'h0);
    @(negedge clk); resetn = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i], 32'h1000 + 32'(i * 4));
      #1 chk($sformatf("vec%0d.de_ready", i), {31'b0, de_ready}, 32'd1);
      if (de_ready) push(vecs[i], 32'h1000 + 32'(i * 4));
      @(posedge clk); #1;
      pop_check($sformatf("vec%0d", i));
    end

    // LW r2 followed by a dependent ADD: one bubble, then MEM forward
    @(negedge clk);
    v = '0; v.op = 4'b0010; v.rs = 5'd1; v.rt = 5'd2; v.rsv = 32'h100; v.imm = 32'h4;
    v.s2imm = 1'b1; v.dest = 5'd2; v.ld = 1'b1; v.ea = 32'h100; v.eb = 32'h4; v.est = 32'h0;
    drive(v, 32'h2000);
    #1 chk("lw.de_ready", {31'b0, de_ready}, 32'd1);
    push(v, 32'h2000);
    @(posedge clk); #1 pop_check("lw");

    @(negedge clk);
    v = '0; v.op = 4'b0010; v.rs = 5'd2; v.rt = 5'd2; v.rsv = 32'hBAD; v.rtv = 32'hBAD;
    v.dest = 5'd6; v.alu = 32'h104; v.ea = 32'hCAFE0001; v.eb = 32'hCAFE0001; v.est = 32'hCAFE0001;
    drive(v, 32'h2004);
    #1 chk("luse.de_ready_stall", {31'b0, de_ready}, 32'd0);
    @(posedge clk); #1 chk("luse.bubble", {31'b0, ex_valid}, 32'd0);
    @(negedge clk);
    mem_valid = 1'b1; mem_dest = 5'd2; mem_result = 32'hCAFE0001;
    #1 chk("luse.de_ready_go", {31'b0, de_ready}, 32'd1);
    push(v, 32'h2004);
    @(posedge clk); #1 pop_check("luse.add");

    // Load in stage, shift reading rs as sa: rs is not compared, no stall
    @(negedge clk);
    v = '0; v.op = 4'b0010; v.rs = 5'd1; v.rt = 5'd2; v.rsv = 32'h200; v.imm = 32'h8;
    v.s2imm = 1'b1; v.dest = 5'd2; v.ld = 1'b1; v.ea = 32'h200; v.eb = 32'h8; v.est = 32'h0;
    drive(v, 32'h2008);
    push(v, 32'h2008);
    @(posedge clk); #1 pop_check("lw2");
    @(negedge clk);
    v = '0; v.op = 4'b0101; v.rs = 5'd2; v.rt = 5'd3; v.rtv = 32'h8; v.sa = 5'd4;
    v.s1sa = 1'b1; v.dest = 5'd9; v.ea = 32'h4; v.eb = 32'h8; v.est = 32'h8;
    drive(v, 32'h200C);
    #1 chk("sa_nohaz.de_ready", {31'b0, de_ready}, 32'd1);
    push(v, 32'h200C);
    @(posedge clk); #1 pop_check("sa_nohaz");

    // Back-pressure: 3 cycles of mem_allowin=0 with decode waiting
    @(negedge clk);
    v = '0; v.op = 4'b1010; v.rs = 5'd20; v.rt = 5'd21; v.rsv = 32'hF0F0; v.rtv = 32'h0FF0;
    v.dest = 5'd22; v.ea = 32'hF0F0; v.eb = 32'h0FF0; v.est = 32'h0FF0;
    drive(v, 32'h3000);
    mem_allowin = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("bp%0d.de_ready", c), {31'b0, de_ready}, 32'd0);
      @(posedge clk); #1;
      check_out($sformatf("bp%0d.hold", c), last_e);
      @(negedge clk);
    end
    mem_allowin = 1'b1;
    #1 chk("bp.release_ready", {31'b0, de_ready}, 32'd1);
    push(v, 32'h3000);
    @(posedge clk); #1 pop_check("bp.capture");

    // Asynchronous reset mid-stream, observed before any clock edge
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("areset.valid", {31'b0, ex_valid}, 32'd0);
    chk("areset.a", ex_alu_a, 32'h0);
    chk("areset.b", ex_alu_b, 32'h0);
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
